// File: rtl/dec3_sched_pkg.sv
// Shared types and constants for the decoder3 select scheduler.
package dec3_sched_pkg;

    localparam int NREQ  = 7;
    localparam int CNT_W = 8;
    localparam logic [2:0] PARK_CODE = 3'd0;

    typedef enum logic [1:0] {
        ST_PARK,
        ST_ON,
        ST_DEAD
    } state_t;

    // Requester index reached by stepping forward from base, wrapping over NREQ.
    function automatic logic [2:0] rr_step(input logic [2:0] base, input int unsigned step);
        return 3'((32'(base) + step) % 32'(NREQ));
    endfunction

endpackage

// File: rtl/dec3_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping, with ptr itself last.
module dec3_rr_pick
    import dec3_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      win,
    output logic            vld
);

    logic [2:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        win = ptr;
        vld = 1'b0;
        idx = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = rr_step(ptr, k);
            if (req[idx]) begin
                win = idx;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder3_sched.sv
// Break-before-make round-robin owner of the 3-to-8 decoder select.
// Optional max-hold preemption is built only when DEC3_MAXHOLD_EN is defined.
module decoder3_sched
    import dec3_sched_pkg::*;
#(
    parameter int HOLD_MIN = 4,
    parameter int DEAD     = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic            CELCLK,
    input  logic            CELRSTN,
    input  logic [NREQ-1:0] req,
    output logic [2:0]      i,
    output logic [NREQ-1:0] gnt,
    output logic            busy
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MIN);
    localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

    state_t            state;
    logic [2:0]        ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        win;
    logic              win_vld;
    logic              preempt;
    logic              release_ok;

    dec3_rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (win),
        .vld (win_vld)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef DEC3_MAXHOLD_EN
    localparam logic [CNT_W-1:0] MAXH_C = CNT_W'(MAX_HOLD);
    // While ON, gnt is exactly the owner's bit, so req & ~gnt is every other requester.
    assign preempt = (cnt >= MAXH_C) && ((req & ~gnt) != '0);
`else
    assign preempt = 1'b0;
`endif

    // ptr doubles as the current owner while ON.
    assign release_ok = (!req[ptr] && (cnt >= HOLD_C)) || preempt;

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state <= ST_PARK;
            ptr   <= 3'd6;
            cnt   <= '0;
            i     <= PARK_CODE;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_PARK: begin
                    if (win_vld) begin
                        state <= ST_ON;
                        ptr   <= win;
                        cnt   <= CNT_W'(1);
                        i     <= win + 3'd1;
                        gnt   <= NREQ'(1) << win;
                        busy  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (release_ok) begin
                        state <= ST_DEAD;
                        cnt   <= CNT_W'(1);
                        i     <= PARK_CODE;
                        gnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DEAD: begin
                    if (cnt >= DEAD_C) begin
                        state <= ST_PARK;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_PARK;
                    i     <= PARK_CODE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/decoder3_sched.md
# decoder3_sched

Round-robin scheduler that shares the 3-to-8 pin-controlled decoder among seven requesters. It drives the decoder's 3-bit select with break-before-make sequencing: code 0 is the park code, and codes 1..7 each belong to one requester. A minimum on-time and a dead interval on the park code are enforced between owners. It sits directly in front of the decoder select pins in the control loop.

## Interface
Parameters:
- HOLD_MIN, 4, minimum cycles a granted code stays selected (1..255)
- DEAD, 2, cycles the park code is held after any owner releases (1..255)
- MAX_HOLD, 64, preemption limit in cycles; used only with DEC3_MAXHOLD_EN (must be greater than HOLD_MIN)

Ports:
- CELCLK  in  1  the single clock; all state is on the rising edge
- CELRSTN  in  1  asynchronous, active-low reset
- req  in  7  request; req[k] asks for decoder code k+1
- i  out  3  decoder select; 0 is the park code
- gnt  out  7  one-hot grant; gnt[k] high exactly while i == k+1
- busy  out  1  high in ON or DEAD

## Operation
- Three states:
  - PARK: i=0, gnt=0.
  - ON: i=owner code, gnt one-hot.
  - DEAD: i=0, gnt=0.
- PARK with any req bit set:
  - Select the winner round-robin, starting at the requester after the last owner.
  - After reset the search starts at req[0].
  - Go to ON and load the hold counter.
- ON:
  - Count cycles.
  - Leave for DEAD when the owner's req is low and the count is at least HOLD_MIN.
  - The owner's req dropping early does not shorten the on-time.
  - Other requests never preempt the owner, except as described in Configuration.
- DEAD:
  - Count DEAD cycles, then return to PARK.
  - Requests arriving during DEAD are held off. They are evaluated in PARK.
- The last-owner pointer updates on entry to ON.
- A req bit that pulses only while the scheduler is not in PARK is lost. Requesters hold req until they see gnt.
- All outputs are registered. i and gnt change on the same edge, so the decoder never sees a select that has no matching grant.
- Counters are 8 bits and saturate. They never wrap.

## Timing
- Reset values: i=0, gnt=0, busy=0, state PARK, pointer=6 so that req[0] wins first.
- Reset asserted mid-ON forces i=0 immediately, because the reset is asynchronous. There is no dead interval after reset.
- Request to grant latency: req sampled high in PARK at edge n gives i/gnt valid after edge n, i.e. 1 cycle.
- Minimum ON duration is HOLD_MIN cycles.
- Release to park latency: owner req sampled low at edge m, with the hold satisfied, gives i=0 after edge m.
- The park code is held for exactly DEAD cycles, then PARK lasts at least 1 cycle.
- Back-to-back handover between two owners therefore takes DEAD+1 cycles of i=0.
- If the owner's req is high again on the release edge, the release does not occur and the owner stays in ON.
- busy rises with gnt and falls on the edge that enters PARK.

## Configuration
- DEC3_MAXHOLD_EN defined:
  - In ON, once the count reaches MAX_HOLD and any other req bit is set, go to DEAD even if the owner's req is still high.
  - The preempted owner is last in the round-robin order for the next arbitration.
- DEC3_MAXHOLD_EN undefined:
  - No preemption. MAX_HOLD is ignored and no comparator is built.

## Structure
- Package dec3_sched_pkg holds:
  - the state enum (PARK, ON, DEAD);
  - PARK_CODE = 3'd0;
  - NREQ = 7;
  - the counter width constant.
- Sub-module dec3_rr_pick, purely combinational:
  - inputs: req[6:0] and pointer;
  - outputs: the winner index and a valid flag.
- The top holds the FSM, the counters and the output registers.

## Test plan
- Reset with req=0 → i=0, gnt=0, busy=0 and they stay so. Assert CELRSTN low during ON → i=0 with no clock edge.
- Pulse req[2] for 1 cycle in PARK (HOLD_MIN=4, DEAD=2) → i=3, gnt=0000100 for exactly 4 cycles, then i=0 for 2 cycles, then PARK.
- Hold req[0] and req[5] high continuously → grants alternate 1,6,1,6. Each handover shows exactly 3 cycles of i=0.
- Hold req=7'h7F → grant order is codes 1,2,...,7,1. Every cycle, gnt is one-hot and matches i.
- Owner req[4] drops at cycle 2 of ON and re-asserts at cycle 3 → owner stays in ON. It releases only on the first sampled low after 4 cycles.
- With DEC3_MAXHOLD_EN, MAX_HOLD=8: req[1] held, req[3] raised at cycle 2 → code 2 is preempted after 8 cycles, then DEAD, then code 4 is granted. Without the macro, code 2 is held indefinitely.
